injection_queue: RTL and testbench

- Source-side flit generator that sits directly upstream of the router's injection engine and drives its inject_port/inject_req pair.
- The local core pushes packet descriptors (destination, length, tag) into a small FIFO.
- The block serialises each packet into 32-bit flits carrying sequence numbers. It holds each flit until the injection engine grants a free link, and flags starvation when a grant is withheld too long.

---
 rtl/router_pkg.sv | 64 ++++++
 rtl/inj_desc_fifo.sv | 54 +++++
 rtl/injection_queue.sv | 134 +++++++++++++
 tb/tb_injection_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: flit field layout, port codes and the flit-assembly helpers.
package router_pkg;

   localparam int FLIT_W      = 32;
   localparam int GOLD_LSB    = 0;
   localparam int GOLD_W      = 1;
   localparam int EJ_LSB      = 1;
   localparam int EJ_W        = 1;
   localparam int INPORT_LSB  = 2;
   localparam int INPORT_W    = 2;
   localparam int OUTPORT_LSB = 4;
   localparam int OUTPORT_W   = 3;
   localparam int SRC_LSB     = 7;
   localparam int SRC_W       = 4;
   localparam int DST_LSB     = 11;
   localparam int DST_W       = 4;
   localparam int SEQ_LSB     = 15;
   localparam int SEQ_W       = 5;
   localparam int TAG_LSB     = 20;
   localparam int TAG_W       = 12;
   localparam int LEN_W       = 5;
   localparam int DESC_W      = TAG_W + LEN_W + DST_W;

   typedef enum logic [2:0] {
      PORT_N     = 3'b000,
      PORT_E     = 3'b001,
      PORT_S     = 3'b010,
      PORT_W     = 3'b011,
      PORT_LOCAL = 3'b100
   } port_e;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [LEN_W-1:0] len;
      logic [DST_W-1:0] dst;
   } desc_t;

   // Router stages overwrite golden/ejected/in-port/out-port, so they leave here as zero.
   function automatic logic [FLIT_W-1:0] make_flit(input logic [SRC_W-1:0] src,
                                                   input logic [DST_W-1:0] dst,
                                                   input logic [SEQ_W-1:0] seq,
                                                   input logic [TAG_W-1:0] tag);
      logic [FLIT_W-1:0] f;
      f = '0;
      f[GOLD_LSB +: GOLD_W]       = '0;
      f[EJ_LSB +: EJ_W]           = '0;
      f[INPORT_LSB +: INPORT_W]   = INPORT_W'(PORT_N);
      f[OUTPORT_LSB +: OUTPORT_W] = PORT_N;
      f[SRC_LSB +: SRC_W]         = src;
      f[DST_LSB +: DST_W]         = dst;
      f[SEQ_LSB +: SEQ_W]         = seq;
      f[TAG_LSB +: TAG_W]         = tag;
      return f;
   endfunction

   function automatic logic [FLIT_W-1:0] set_seq(input logic [FLIT_W-1:0] flit,
                                                 input logic [SEQ_W-1:0] seq);
      logic [FLIT_W-1:0] f;
      f = flit;
      f[SEQ_LSB +: SEQ_W] = seq;
      return f;
   endfunction

endpackage

// File: rtl/inj_desc_fifo.sv
// Synchronous circular descriptor FIFO; head entry is visible combinationally on rd_data.
module inj_desc_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = DESC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      rd_data  = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/injection_queue.sv
// Source-side flit generator: queues packet descriptors and serialises them into
// registered flits for the injection engine, with grant-starvation detection.
module injection_queue
   import router_pkg::*;
#(
   parameter logic [3:0] NODE_ID      = 4'h0,
   parameter int         DEPTH        = 4,
   parameter int         STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        desc_valid,
   output logic        desc_ready,
   input  logic [3:0]  desc_dst,
   input  logic [4:0]  desc_len,
   input  logic [11:0] desc_tag,
   output logic [31:0] inject_port,
   output logic        inject_req,
   input  logic        inject_grand,
   output logic        starve,
   output logic        drop_len,
   output logic [15:0] flits_sent,
   output logic [15:0] pkts_sent
);

   typedef enum logic {ST_IDLE, ST_SEND} state_e;

   localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

   state_e            state_q, state_d;
   logic [FLIT_W-1:0] flit_q, flit_d;
   logic              req_q, req_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [15:0]       flits_q, flits_d;
   logic [15:0]       pkts_q, pkts_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              starve_q, starve_d;
   logic              drop_q, drop_d;
   logic              push, pop, load, full, empty;
   logic [DESC_W-1:0] rd_data;
   desc_t             head;

   inj_desc_fifo #(.DEPTH(DEPTH), .W(DESC_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data ({desc_tag, desc_len, desc_dst}),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty)
   );

   assign head = desc_t'(rd_data);

   always_comb begin
      state_d = state_q;
      flit_d  = flit_q;
      seq_d   = seq_q;
      len_d   = len_q;
      flits_d = flits_q;
      pkts_d  = pkts_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: load = ~empty;
         ST_SEND: begin
            if (inject_grand) begin
               flits_d = flits_q + 16'd1;
               if (seq_q != len_q - 5'd1) begin
                  seq_d  = seq_q + 5'd1;
                  flit_d = set_seq(flit_q, seq_q + 5'd1);
               end else begin
                  pkts_d = pkts_q + 16'd1;
                  if (!empty) load = 1'b1;
                  else        state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Loading the next head on the final grant keeps packets back-to-back.
      pop = load;
      if (load) begin
         seq_d   = '0;
         len_d   = head.len;
         flit_d  = make_flit(NODE_ID, head.dst, '0, head.tag);
         state_d = ST_SEND;
      end
      req_d = (state_d == ST_SEND);

      if (req_q && !inject_grand) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      else                        cnt_d = 8'd0;
      starve_d = (cnt_d >= STARVE_LIM8);

      push   = desc_valid & ~full & (desc_len != 5'd0);
      drop_d = desc_valid & ~full & (desc_len == 5'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         flit_q   <= '0;
         req_q    <= 1'b0;
         seq_q    <= '0;
         len_q    <= '0;
         flits_q  <= '0;
         pkts_q   <= '0;
         cnt_q    <= '0;
         starve_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         flit_q   <= flit_d;
         req_q    <= req_d;
         seq_q    <= seq_d;
         len_q    <= len_d;
         flits_q  <= flits_d;
         pkts_q   <= pkts_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         drop_q   <= drop_d;
      end
   end

   assign desc_ready  = ~full;
   assign inject_port = flit_q;
   assign inject_req  = req_q;
   assign starve      = starve_q;
   assign drop_len    = drop_q;
   assign flits_sent  = flits_q;
   assign pkts_sent   = pkts_q;

endmodule

// File: tb/tb_injection_queue.sv
// Directed bench for injection_queue: queue-based reference model compared every cycle,
// plus literal expectations taken from hand-computed flit values.
module tb_injection_queue;

   localparam logic [3:0] NODE_ID      = 4'h1;
   localparam int         DEPTH        = 4;
   localparam int         STARVE_LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        desc_valid = 1'b0;
   logic        desc_ready;
   logic [3:0]  desc_dst = '0;
   logic [4:0]  desc_len = '0;
   logic [11:0] desc_tag = '0;
   logic [31:0] inject_port;
   logic        inject_req;
   logic        inject_grand = 1'b0;
   logic        starve;
   logic        drop_len;
   logic [15:0] flits_sent;
   logic [15:0] pkts_sent;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   injection_queue #(.NODE_ID(NODE_ID), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .desc_valid   (desc_valid),
      .desc_ready   (desc_ready),
      .desc_dst     (desc_dst),
      .desc_len     (desc_len),
      .desc_tag     (desc_tag),
      .inject_port  (inject_port),
      .inject_req   (inject_req),
      .inject_grand (inject_grand),
      .starve       (starve),
      .drop_len     (drop_len),
      .flits_sent   (flits_sent),
      .pkts_sent    (pkts_sent)
   );

   // ---------------- reference model ----------------
   typedef struct {int dst; int len; int tag;} mdesc_t;
   mdesc_t      mq[$];
   mdesc_t      cur;
   int          m_seq = 0;
   bit          m_req = 0;
   int          m_flits = 0;
   int          m_pkts = 0;
   int          m_stall = 0;
   bit          m_drop = 0;
   bit          m_port_known = 1;
   logic [31:0] m_port = '0;
   bit          m_rdy;
   bit          m_push;

   function automatic logic [31:0] exp_flit(int dst, int seq, int tag);
      longint v;
      v = longint'(tag) * 1048576 + longint'(seq) * 32768 + longint'(dst) * 2048
        + longint'(NODE_ID) * 128;
      return v[31:0];
   endfunction

   task automatic m_load();
      cur          = mq.pop_front();
      m_seq        = 0;
      m_req        = 1;
      m_port       = exp_flit(cur.dst, 0, cur.tag);
      m_port_known = 1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_req = 0; m_seq = 0; m_flits = 0; m_pkts = 0; m_stall = 0; m_drop = 0;
         m_port = '0; m_port_known = 1;
      end else begin
         m_rdy  = (mq.size() < DEPTH);
         m_push = desc_valid && m_rdy && (desc_len != 0);
         m_drop = desc_valid && m_rdy && (desc_len == 0);
         if (m_req && !inject_grand) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
         else                        m_stall = 0;
         if (m_req && inject_grand) begin
            m_flits = (m_flits + 1) % 65536;
            $display("flit granted: %08h (dst=%0d seq=%0d tag=%03h)", m_port, cur.dst, m_seq, cur.tag);
            if (m_seq < cur.len - 1) begin
               m_seq  = m_seq + 1;
               m_port = exp_flit(cur.dst, m_seq, cur.tag);
            end else begin
               m_pkts = (m_pkts + 1) % 65536;
               if (mq.size() > 0) m_load();
               else begin
                  m_req        = 0;
                  m_port_known = 0;
               end
            end
         end else if (!m_req && mq.size() > 0) begin
            m_load();
         end
         if (m_push) mq.push_back('{int'(desc_dst), int'(desc_len), int'(desc_tag)});
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp("model.req",    32'(inject_req), 32'(m_req));
         cmp("model.ready",  32'(desc_ready), 32'(mq.size() < DEPTH));
         cmp("model.starve", 32'(starve),     32'(m_stall >= STARVE_LIMIT));
         cmp("model.drop",   32'(drop_len),   32'(m_drop));
         cmp("model.flits",  32'(flits_sent), 32'(m_flits));
         cmp("model.pkts",   32'(pkts_sent),  32'(m_pkts));
         if (m_req || m_port_known) cmp("model.port", inject_port, m_port);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic offer(input logic [3:0] dst, input logic [4:0] len, input logic [11:0] tag);
      desc_valid = 1'b1;
      desc_dst   = dst;
      desc_len   = len;
      desc_tag   = tag;
   endtask

   logic [31:0] bb_exp [4];
   logic [31:0] full_exp;

   initial begin
      tick(); tick();
      rst = 1'b0;
      cmp_en = 1'b1;
      sample();
      cmp("reset.req",   32'(inject_req), 32'd0);
      cmp("reset.port",  inject_port,     32'h0);
      cmp("reset.ready", 32'(desc_ready), 32'd1);
      cmp("reset.flits", 32'(flits_sent), 32'd0);

      // Basic packet, grant held high
      inject_grand = 1'b1;
      tick();
      offer(4'd3, 5'd2, 12'hABC);
      tick();
      desc_valid = 1'b0;
      sample();
      cmp("basic.bubble", 32'(inject_req), 32'd0);
      tick();
      sample();
      cmp("basic.req0",  32'(inject_req), 32'd1);
      cmp("basic.flit0", inject_port,     32'hABC01880);
      tick();
      sample();
      cmp("basic.flit1", inject_port,     32'hABC09880);
      tick();
      sample();
      cmp("basic.req_off", 32'(inject_req), 32'd0);
      cmp("basic.flits",   32'(flits_sent), 32'd2);
      cmp("basic.pkts",    32'(pkts_sent),  32'd1);

      // Grant stall of 10 cycles
      tick();
      inject_grand = 1'b0;
      offer(4'd3, 5'd2, 12'hABC);
      tick();
      desc_valid = 1'b0;
      tick();
      for (int k = 1; k <= 10; k++) begin
         sample();
         cmp("stall.port",   inject_port,     32'hABC01880);
         cmp("stall.starve", 32'(starve),     32'(k >= 9));
         tick();
      end
      inject_grand = 1'b1;
      sample();
      cmp("stall.starve_at_grant", 32'(starve), 32'd1);
      tick();
      sample();
      cmp("stall.starve_clear", 32'(starve), 32'd0);
      cmp("stall.seq1",         inject_port, 32'hABC09880);
      tick();
      sample();
      cmp("stall.pkts", 32'(pkts_sent), 32'd2);

      // Back-to-back packets
      bb_exp[0] = 32'h00101080;
      bb_exp[1] = 32'h00202880;
      bb_exp[2] = 32'h0020A880;
      bb_exp[3] = 32'h00212880;
      tick();
      offer(4'd2, 5'd1, 12'h001);
      tick();
      offer(4'd5, 5'd3, 12'h002);
      tick();
      desc_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sample();
         cmp("b2b.req",  32'(inject_req), 32'd1);
         cmp("b2b.port", inject_port,     bb_exp[i]);
         tick();
      end
      sample();
      cmp("b2b.req_off", 32'(inject_req), 32'd0);
      cmp("b2b.pkts",    32'(pkts_sent),  32'd4);
      cmp("b2b.flits",   32'(flits_sent), 32'd8);

      // FIFO full: engine stalled on a first packet while five more are offered
      tick();
      inject_grand = 1'b0;
      offer(4'd0, 5'd1, 12'h100);
      tick();
      desc_valid = 1'b0;
      tick();
      for (int i = 1; i <= 5; i++) begin
         offer(4'(i), 5'd1, 12'h100 + 12'(i));
         sample();
         cmp("full.ready", 32'(desc_ready), 32'(i <= 4));
         tick();
      end
      desc_valid = 1'b0;
      sample();
      cmp("full.ready_after", 32'(desc_ready), 32'd0);
      tick();
      inject_grand = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         full_exp = (32'h100 + 32'(i)) << 20 | (32'(i) << 11) | 32'h80;
         sample();
         cmp("full.req",  32'(inject_req), 32'd1);
         cmp("full.port", inject_port,     full_exp);
         tick();
      end
      sample();
      cmp("full.req_off", 32'(inject_req), 32'd0);
      cmp("full.ready",   32'(desc_ready), 32'd1);

      // Zero-length descriptor
      tick();
      offer(4'd7, 5'd0, 12'h555);
      tick();
      desc_valid = 1'b0;
      sample();
      cmp("zero.drop", 32'(drop_len),   32'd1);
      cmp("zero.req",  32'(inject_req), 32'd0);
      tick();
      sample();
      cmp("zero.drop_off", 32'(drop_len),   32'd0);
      cmp("zero.req_off",  32'(inject_req), 32'd0);
      tick();
      sample();
      cmp("zero.req_still", 32'(inject_req), 32'd0);

      // Reset mid-packet with another descriptor queued
      tick();
      offer(4'd9, 5'd5, 12'h777);
      tick();
      offer(4'd10, 5'd2, 12'h888);
      tick();
      desc_valid = 1'b0;
      sample();
      cmp("rst.flit0", inject_port, 32'h77704880);
      tick();
      sample();
      cmp("rst.flit1", inject_port, 32'h7770C880);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sample();
      cmp("rst.req",   32'(inject_req), 32'd0);
      cmp("rst.port",  inject_port,     32'h0);
      cmp("rst.flits", 32'(flits_sent), 32'd0);
      cmp("rst.pkts",  32'(pkts_sent),  32'd0);
      cmp("rst.ready", 32'(desc_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         sample();
         cmp("rst.no_flits", 32'(inject_req), 32'd0);
      end

      tick();
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
